pe_dot_ctrl: RTL and testbench

Sequencer wrapping one FMA-mode `pe` into a streaming signed dot-product engine. It accepts a job descriptor (length K and bias), streams K activation/weight pairs through the PE, and feeds the PE's registered output back as its addend. It returns bias + Σ act·wgt on a valid/ready result port. It sits between the systolic-array operand buffers and the output/accumulator buffer, and is the unit replicated per PE column.

---
 rtl/pe_dot_pkg.sv | 16 +
 rtl/pe.sv | 37 +++
 rtl/pe_dot_ctrl.sv | 118 +++++++++++
 tb/tb_pe_dot_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_dot_pkg.sv
// rtl/pe_dot_pkg.sv - shared state encoding for the dot-product sequencer
package pe_dot_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ACCUM  = 2'd1;
  localparam logic [STATE_W-1:0] RESULT = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = IDLE,
    S_ACCUM  = ACCUM,
    S_RESULT = RESULT
  } state_e;

endpackage

// File: rtl/pe.sv
// rtl/pe.sv - processing element: registered signed a*b (+c in FMA mode)
module pe #(
  parameter string PE_MODE      = "FMA",
  parameter int    ACT_WIDTH    = 16,
  parameter int    WGT_WIDTH    = 16,
  parameter int    PE_OUT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [ACT_WIDTH-1:0]    a,
  input  logic signed [WGT_WIDTH-1:0]    b,
  input  logic signed [PE_OUT_WIDTH-1:0] c,
  output logic signed [PE_OUT_WIDTH-1:0] out
);

  logic signed [ACT_WIDTH+WGT_WIDTH-1:0] prod;
  logic signed [PE_OUT_WIDTH-1:0]        prod_ext;
  logic signed [PE_OUT_WIDTH-1:0]        nxt;

  assign prod     = a * b;
  assign prod_ext = PE_OUT_WIDTH'(prod);

  // Plain two's complement add: wraps mod 2^PE_OUT_WIDTH, no saturation.
  generate
    if (PE_MODE == "FMA") begin : g_fma
      assign nxt = prod_ext + c;
    end else begin : g_mul
      assign nxt = prod_ext;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= '0;
    else       out <= nxt;
  end

endmodule

// File: rtl/pe_dot_ctrl.sv
// rtl/pe_dot_ctrl.sv - streaming signed dot-product sequencer around one FMA pe
module pe_dot_ctrl
  import pe_dot_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int WGT_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [ACC_WIDTH-1:0] cfg_bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [WGT_WIDTH-1:0] in_wgt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 busy
);

  state_e                 state;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   cnt;
  logic signed [ACT_WIDTH-1:0] pe_a;
  logic signed [WGT_WIDTH-1:0] pe_b;
  logic signed [ACC_WIDTH-1:0] pe_c;
  logic signed [ACC_WIDTH-1:0] pe_out;

  // The PE register is the accumulator; every non-accept cycle re-adds 0 to it.
  always_comb begin
    pe_a = '0;
    pe_b = '0;
    pe_c = pe_out;
    if (state == S_IDLE && cfg_valid) begin
      pe_c = cfg_bias;
    end else if (state == S_ACCUM && in_valid) begin
      pe_a = in_act;
      pe_b = in_wgt;
    end
  end

  pe #(
    .PE_MODE     ("FMA"),
    .ACT_WIDTH   (ACT_WIDTH),
    .WGT_WIDTH   (WGT_WIDTH),
    .PE_OUT_WIDTH(ACC_WIDTH)
  ) u_pe (
    .clk  (clk),
    .reset(reset),
    .a    (pe_a),
    .b    (pe_b),
    .c    (pe_c),
    .out  (pe_out)
  );

  assign out_data = pe_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt       <= '0;
      cfg_ready <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            len_q     <= cfg_len;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            if (cfg_len == '0) begin
              state     <= S_RESULT;
              out_valid <= 1'b1;
            end else begin
              state    <= S_ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            cnt <= cnt + LEN_WIDTH'(1);
            if (cnt == len_q - LEN_WIDTH'(1)) begin
              state     <= S_RESULT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// tb/tb_pe_dot_ctrl.sv - self-checking bench for pe_dot_ctrl
module tb_pe_dot_ctrl;

  localparam int AW = 16;
  localparam int WW = 16;
  localparam int CW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_bias;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_act;
  logic [WW-1:0] in_wgt;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  pe_dot_ctrl #(
    .ACT_WIDTH(AW), .WGT_WIDTH(WW), .ACC_WIDTH(CW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  typedef struct {
    int          len;
    logic [31:0] bias;
    int          act[8];
    int          wgt[8];
    logic [15:0] vmask;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int          beat;
    int          cyc;
    int          guard;
    logic        vb;
    logic [31:0] prev;
    logic [31:0] exp_out;
    @(negedge clk);
    guard = 0;
    while (!cfg_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    check("in_ready_idle", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b1;
    in_act    = 16'h1234;
    in_wgt    = 16'h0101;
    cfg_valid = 1'b1;
    cfg_len   = LW'(v.len);
    cfg_bias  = v.bias;
    out_ready = 1'b0;
    sb.push_back(v.exp);
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("busy_after_cfg", {31'd0, busy}, 32'd1);
    if (v.len == 0) begin
      check("in_ready_k0", {31'd0, in_ready}, 32'd0);
    end else begin
      check("in_ready_lat", {31'd0, in_ready}, 32'd1);
      check("bias_loaded", out_data, v.bias);
      beat = 0;
      cyc  = 0;
      while (beat < v.len && cyc < 100) begin
        vb   = (cyc < 16) ? v.vmask[cyc] : 1'b1;
        prev = out_data;
        if (vb) begin
          in_valid = 1'b1;
          in_act   = AW'(v.act[beat]);
          in_wgt   = WW'(v.wgt[beat]);
          beat++;
        end else begin
          in_valid = 1'b0;
          in_act   = 16'h7FFF;
          in_wgt   = 16'h7FFF;
        end
        @(negedge clk);
        if (!vb) check("stall_hold", out_data, prev);
        cyc++;
      end
      in_valid = 1'b0;
    end
    check("out_valid_lat", {31'd0, out_valid}, 32'd1);
    check("in_ready_result", {31'd0, in_ready}, 32'd0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_out = sb.pop_front();
      check("result", out_data, exp_out);
    end
    prev = out_data;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, prev);
      check("hold_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    end
    // Descriptor offered in the accepting RESULT cycle must be ignored.
    out_ready = 1'b1;
    cfg_valid = 1'b1;
    cfg_len   = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    out_ready = 1'b0;
    check("cfg_ready_after", {31'd0, cfg_ready}, 32'd1);
    check("out_valid_after", {31'd0, out_valid}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vecs[0] = '{len:3, bias:32'd10, act:'{2,-4,7,0,0,0,0,0}, wgt:'{3,5,-1,0,0,0,0,0},
                vmask:16'hFFFF, hold:5, exp:32'hFFFF_FFF5};
    vecs[1] = '{len:0, bias:32'hFFFF_FFFB, act:'{0,0,0,0,0,0,0,0}, wgt:'{0,0,0,0,0,0,0,0},
                vmask:16'hFFFF, hold:0, exp:32'hFFFF_FFFB};
    vecs[2] = '{len:4, bias:32'd0, act:'{1,1,1,1,0,0,0,0}, wgt:'{1,1,1,1,0,0,0,0},
                vmask:16'hFFD9, hold:1, exp:32'd4};
    vecs[3] = '{len:1, bias:32'h7FFF_FFFF, act:'{1,0,0,0,0,0,0,0}, wgt:'{1,0,0,0,0,0,0,0},
                vmask:16'hFFFF, hold:0, exp:32'h8000_0000};
    vecs[4] = '{len:2, bias:32'hFFFF_FF9C, act:'{-32768,1,0,0,0,0,0,0}, wgt:'{-32768,-1,0,0,0,0,0,0},
                vmask:16'hFFFF, hold:0, exp:32'd1073741723};
    vecs[5] = '{len:1, bias:32'd0, act:'{3,0,0,0,0,0,0,0}, wgt:'{3,0,0,0,0,0,0,0},
                vmask:16'hFFFF, hold:0, exp:32'd9};
    vecs[6].len   = 8;
    vecs[6].bias  = 32'($urandom);
    vecs[6].vmask = 16'hF5AB;
    vecs[6].hold  = 2;
    acc = int'(vecs[6].bias);
    for (int i = 0; i < 8; i++) begin
      vecs[6].act[i] = int'($urandom_range(0, 65535)) - 32768;
      vecs[6].wgt[i] = int'($urandom_range(0, 65535)) - 32768;
      acc += vecs[6].act[i] * vecs[6].wgt[i];
    end
    vecs[6].exp = 32'(acc);

    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_len   = '0;
    cfg_bias  = '0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    for (int i = 0; i < 5; i++) run_job(vecs[i]);
    run_job(vecs[6]);

    // Asynchronous reset after 2 of 5 beats aborts the job.
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_len   = 16'd5;
    cfg_bias  = 32'd7;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    in_act    = 16'd2;
    in_wgt    = 16'd2;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("pre_abort_data", out_data, 32'd15);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_job(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
